// File: rtl/control_unit.sv
// Hard-wired sequencer for the 32-bit datapath: fetch in T0-T2, execute in T3-T6.
// The state register and next-state logic are separate; output strobes are decoded from state and the IR opcode.
module control_unit #(
  parameter int unsigned    OPW     = 5,
  parameter logic [OPW-1:0] NOP_OP  = 5'b11010,
  parameter logic [OPW-1:0] HALT_OP = 5'b11011
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    RST  = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  state_t         cur, nxt;
  logic [OPW-1:0] op;
  logic           is_alu, is_muldiv, is_exec;
  logic           unused_ir;

  assign op = IR[31 -: OPW];
  // Register-field bits are consumed by the datapath's select-and-encode logic.
  assign unused_ir = ^IR[31-OPW:0];

  always_comb begin
    is_alu    = 1'b0;
    is_muldiv = 1'b0;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b10001, 5'b10010: is_alu    = 1'b1;
      5'b01111, 5'b10000:                     is_muldiv = 1'b1;
      default: ;
    endcase
    is_exec = (op != NOP_OP) && (is_alu || is_muldiv);
  end

  always_ff @(posedge Clock) begin
    if (clear) cur <= RST;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      RST:  nxt = T0;
      T0:   nxt = T1;
      T1:   nxt = mem_ready ? T2 : T1;
      T2:   nxt = T3;
      T3: begin
        if (op == HALT_OP) nxt = HALT;
        else if (is_exec)  nxt = T4;
        else               nxt = T0;
      end
      T4:   nxt = T5;
      T5:   nxt = is_muldiv ? T6 : T0;
      T6:   nxt = T0;
      HALT: nxt = HALT;
      default: nxt = RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    alu_op = '0;
    case (cur)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: if (is_exec) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      T4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = 5'(op); end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      T6: begin Zhighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

  assign run   = (cur != RST) && (cur != HALT);
  assign state = cur;

endmodule
